// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Define ARB_PERF_CNT_EN to add per-port wait-cycle counters.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          stall_o,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]   perf_if_wait_o,
  output logic [31:0]   perf_dm_wait_o,
`endif
  output logic          err_o
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, RESP} state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          sel_dm_q, sel_dm_d;
  logic [3:0]    starve_q, starve_d;
  logic [7:0]    timer_q, timer_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          err_q, err_d;
  logic          grant_dm;

  always_comb begin
    state_d     = state_q;
    sel_dm_d    = sel_dm_q;
    starve_d    = starve_q;
    timer_d     = timer_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    grant_dm    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          // Data wins ties until fetch has lost STARVE_LIMIT times in a row.
          grant_dm    = dm_req_i && !(if_req_i && (starve_q == STARVE_MAX));
          sel_dm_d    = grant_dm;
          state_d     = grant_dm ? GNT_DM : GNT_IF;
          mem_we_d    = grant_dm && dm_we_i;
          mem_addr_d  = grant_dm ? dm_addr_i : if_addr_i;
          mem_wdata_d = grant_dm ? dm_wdata_i : '0;
          timer_d     = '0;
          if (!grant_dm)
            starve_d = '0;
          else if (if_req_i && (starve_q != STARVE_MAX))
            starve_d = starve_q + 4'd1;
        end
      end
      GNT_IF, GNT_DM: begin
        if (mem_ack_i) begin
          if (!sel_dm_q)     if_rdata_d = mem_rdata_i;
          else if (!mem_we_q) dm_rdata_d = mem_rdata_i;
          state_d = RESP;
        end else if (timer_q == TIMER_LAST) begin
          // Abort: still complete the handshake so the pipeline can move on.
          err_d = 1'b1;
          if (sel_dm_q) dm_rdata_d = '0;
          else          if_rdata_d = '0;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_dm_q    <= 1'b0;
      starve_q    <= '0;
      timer_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_dm_q    <= sel_dm_d;
      starve_q    <= starve_d;
      timer_q     <= timer_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o   = (state_q == GNT_IF) || (state_q == GNT_DM);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = (state_q == RESP) && !sel_dm_q;
  assign dm_ack_o    = (state_q == RESP) && sel_dm_q;
  assign err_o       = err_q;
  assign stall_o     = ((if_req_i | dm_req_i) & ~(if_ack_o | dm_ack_o)) | mem_req_o;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_dm_q, perf_dm_d;

  always_comb begin
    perf_if_d = perf_if_q;
    perf_dm_d = perf_dm_q;
    if (if_req_i && !if_ack_o && (perf_if_q != 32'hFFFF_FFFF)) perf_if_d = perf_if_q + 32'd1;
    if (dm_req_i && !dm_ack_o && (perf_dm_q != 32'hFFFF_FFFF)) perf_dm_d = perf_dm_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_dm_q <= perf_dm_d;
    end
  end

  assign perf_if_wait_o = perf_if_q;
  assign perf_dm_wait_o = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level arbitration and memory model.
module tb_mem_port_arbiter;
  localparam int SL = 3;

  logic        clk_i = 1'b0, rst_n = 1'b1;
  logic        if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o, err_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait_o, perf_dm_wait_o;
`endif

  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .stall_o(stall_o),
`ifdef ARB_PERF_CNT_EN
    .perf_if_wait_o(perf_if_wait_o), .perf_dm_wait_o(perf_dm_wait_o),
`endif
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] memv [16];
  int          wcnt = 0, cur_wait = 0, fixed_wait = 0;
  bit          rand_wait = 0, acked = 0, prev_req = 0, cur_dm = 0, cur_we = 0;
  int          sc = 0, ifw = 0;
  logic [31:0] cur_addr = '0, last_dm = '0;
  bit          aseq [$];
  int          perf_if_tb = 0, perf_dm_tb = 0;
  bit          pif = 0, pdm = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model + memory responder, evaluated once per cycle after the edge.
  task automatic mon();
    logic [31:0] e;
    if (!rst_n) begin
      prev_req = 0; sc = 0; ifw = 0; last_dm = '0; acked = 0;
      perf_if_tb = 0; perf_dm_tb = 0; pif = 0; pdm = 0;
      mem_ack_i = 1'b0; wcnt = 0;
      return;
    end
    perf_if_tb += int'(pif); perf_dm_tb += int'(pdm);
    pif = if_req_i & ~if_ack_o;
    pdm = dm_req_i & ~dm_ack_o;
    chk("stall", 32'(stall_o), 32'(((if_req_i | dm_req_i) & ~(if_ack_o | dm_ack_o)) | mem_req_o));
    if (mem_req_o && !prev_req) begin
      cur_dm   = dm_req_i && !(if_req_i && sc == SL);
      cur_addr = cur_dm ? dm_addr_i : if_addr_i;
      cur_we   = cur_dm && dm_we_i;
      chk("gnt_addr", mem_addr_o, cur_addr);
      chk("gnt_we", 32'(mem_we_o), 32'(cur_we));
      if (cur_we) chk("gnt_wdata", mem_wdata_o, dm_wdata_i);
      if (cur_dm) begin
        if (if_req_i) begin
          if (sc < SL) sc++;
          ifw++;
          chk("if_starve", 32'(ifw <= SL), 1);
        end
      end else begin
        sc = 0; ifw = 0;
      end
    end
    if (if_ack_o || dm_ack_o) begin
      chk("ack_after_gnt", 32'(prev_req), 1);
      chk("resp_req", 32'(mem_req_o), 0);
      chk("ack_port", 32'(dm_ack_o), 32'(cur_dm));
      chk("ack_onehot", 32'(if_ack_o ^ dm_ack_o), 1);
      aseq.push_back(dm_ack_o);
      e = acked ? memv[cur_addr[5:2]] : '0;
      if (!cur_dm) chk("if_rdata", if_rdata_o, e);
      else if (!cur_we) begin chk("dm_rdata", dm_rdata_o, e); last_dm = e; end
      else chk("dm_rdata_store", dm_rdata_o, last_dm);
      acked = 0;
    end
    prev_req = mem_req_o;
    // Memory: ack after a wait; random mode also throws stray acks outside grants.
    if (!mem_req_o) begin
      mem_ack_i   = rand_wait ? 1'($urandom_range(1)) : 1'b0;
      mem_rdata_i = $urandom;
      wcnt = 0;
    end else begin
      if (wcnt == 0) cur_wait = rand_wait ? int'($urandom_range(3)) : fixed_wait;
      if (wcnt >= cur_wait) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = memv[mem_addr_o[5:2]];
        if (mem_we_o) memv[mem_addr_o[5:2]] = mem_wdata_o;
        acked = 1;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
      end
      wcnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1; mon(); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input bit dm, input int max, input string tag);
    bit got = 0;
    for (int i = 0; i < max && !got; i++) begin
      tick();
      if (dm ? dm_ack_o : if_ack_o) begin
        got = 1;
        if (dm) dm_req_i = 1'b0; else if_req_i = 1'b0;
      end
    end
    chk(tag, 32'(got), 1);
  endtask

  initial begin
    int n, acks, gc;
    bit pat [8];
    for (int i = 0; i < 16; i++) memv[i] = $urandom;
    memv[0] = 32'h2001_000A;
    memv[2] = 32'hDEAD_BEEF;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_mem_we", 32'(mem_we_o), 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_acks", 32'({if_ack_o, dm_ack_o}), 0);
    chk("rst_err", 32'(err_o), 0);
    tick(); tick();
    rst_n = 1'b1;

    // IF-only, zero-wait
    fixed_wait = 0; rand_wait = 0;
    if_addr_i = 32'h0; if_req_i = 1'b1;
    tick();
    chk("if0_ack_early", 32'(if_ack_o), 0);
    chk("if0_mem_req", 32'(mem_req_o), 1);
    tick();
    chk("if0_ack", 32'(if_ack_o), 1);
    chk("if0_rdata", if_rdata_o, 32'h2001_000A);
    if_req_i = 1'b0;
    tick();
    chk("if0_stall_after", 32'(stall_o), 0);

    // DM store, 3 wait cycles
    fixed_wait = 3;
    dm_addr_i = 32'h10; dm_wdata_i = 32'h55; dm_we_i = 1'b1; dm_req_i = 1'b1;
    n = 0; acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_req_o && mem_we_o && mem_addr_o == 32'h10) n++;
      if (dm_ack_o) begin acks++; dm_req_i = 1'b0; end
    end
    chk("st_hold_cycles", n, 4);
    chk("st_ack_count", acks, 1);
    chk("st_dm_rdata", dm_rdata_o, 0);
    chk("st_mem_written", memv[4], 32'h55);

    // async reset in the middle of an IF grant
    fixed_wait = 100000;
    if_addr_i = 32'h30; if_req_i = 1'b1;
    tick(); tick();
    chk("rm_in_gnt", 32'(mem_req_o), 1);
    #1 rst_n = 1'b0; if_req_i = 1'b0;
    #1;
    chk("rm_mem_req", 32'(mem_req_o), 0);
    chk("rm_mem_addr", mem_addr_o, 0);
    chk("rm_if_rdata", if_rdata_o, 0);
    chk("rm_stall", 32'(stall_o), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_no_ack", 32'(if_ack_o), 0);
    end
    rst_n = 1'b1;
    fixed_wait = 1;
    if_req_i = 1'b1;
    wait_ack(0, 10, "rm_reissue_ack");

    // both requesting continuously
    do_reset();
    fixed_wait = 0;
    aseq.delete();
    if_addr_i = 32'h20; dm_addr_i = 32'h24; dm_we_i = 1'b0;
    if_req_i = 1'b1; dm_req_i = 1'b1;
    repeat (40) tick();
    pat = '{1, 1, 1, 0, 1, 1, 1, 0};
    chk("starve_count", 32'(aseq.size() >= 8), 1);
    for (int i = 0; i < 8 && i < aseq.size(); i++) chk($sformatf("starve_order%0d", i), 32'(aseq[i]), 32'(pat[i]));
`ifdef ARB_PERF_CNT_EN
    chk("perf_if", perf_if_wait_o, perf_if_tb);
    chk("perf_dm", perf_dm_wait_o, perf_dm_tb);
    chk("perf_if_nz", 32'(perf_if_wait_o != 0), 1);
`endif

    // memory never acks
    do_reset();
    fixed_wait = 100000;
    dm_addr_i = 32'h8; dm_we_i = 1'b0; dm_req_i = 1'b1;
    gc = 0; acks = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_req_o) begin
        gc++;
        if (gc == 1) chk("to_err_before", 32'(err_o), 0);
      end
      if (dm_ack_o) begin
        acks++;
        chk("to_rdata", dm_rdata_o, 0);
        dm_req_i = 1'b0;
      end
    end
    chk("to_gnt_cycles", gc, 16);
    chk("to_ack_count", acks, 1);
    chk("to_err", 32'(err_o), 1);
    fixed_wait = 0;
    if_addr_i = 32'h0; if_req_i = 1'b1;
    wait_ack(0, 10, "to_post_ack");
    tick();
    chk("to_err_sticky", 32'(err_o), 1);
    do_reset();
    chk("to_err_clr", 32'(err_o), 0);

    // random traffic
    rand_wait = 1;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (if_ack_o) if_req_i = 1'b0;
      if (dm_ack_o) dm_req_i = 1'b0;
      if (c < 550) begin
        if (!if_req_i && $urandom_range(2) == 0) begin
          if_addr_i = 32'($urandom_range(15)) << 2; if_req_i = 1'b1;
        end
        if (!dm_req_i && $urandom_range(2) == 0) begin
          dm_addr_i = 32'($urandom_range(15)) << 2; dm_we_i = 1'($urandom_range(1));
          dm_wdata_i = $urandom; dm_req_i = 1'b1;
        end
      end
    end
    chk("rnd_drain", 32'(if_req_i | dm_req_i), 0);
    chk("rnd_err", 32'(err_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
